// File: rtl/fsm_out_collector.sv
// fsm_out_collector: packs the serial bit stream of an upstream Mealy FSM
// into WORD_W-bit words (MSB first) and queues them in a small FIFO.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   in_valid, in_bit      - serial input bit and its qualifier
//   flush                 - discard the partial word (wins over in_valid)
//   ovf_clr               - clear the sticky overflow flag
//   out_ready             - consumer accepts the head word
//   out_valid, out_data   - FIFO non-empty, head word (0 when empty)
//   bit_cnt               - bits held in the partial word
//   overflow              - sticky: a completed word was dropped
//   out_parity            - XOR of the head word (FSM_OUT_COLLECTOR_PARITY_EN)
// Optional feature macro: FSM_OUT_COLLECTOR_PARITY_EN
module fsm_out_collector #(
    parameter int WORD_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_bit,
    input  logic              flush,
    input  logic              ovf_clr,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_data,
    output logic [4:0]        bit_cnt,
`ifdef FSM_OUT_COLLECTOR_PARITY_EN
    output logic              out_parity,
`endif
    output logic              overflow
);

    localparam int         AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [4:0] LAST = 5'(WORD_W - 1);
    localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_COLLECT = 1'b1
    } state_t;

    state_t            r_state;
    logic [WORD_W-1:0] r_shift;
    logic [4:0]        r_bit_cnt;
    logic [WORD_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [AW:0]       r_count;
    logic              r_overflow;

    logic              w_complete;
    logic [WORD_W-1:0] w_word;
    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;

    assign w_complete = in_valid & ~flush & (r_bit_cnt == LAST);
    assign w_word     = {r_shift[WORD_W-2:0], in_bit};
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == FULL);
    assign w_pop      = ~w_empty & out_ready;
    // A full FIFO still takes the word if the head leaves on the same edge.
    assign w_push     = w_complete & (~w_full | w_pop);
    assign w_drop     = w_complete & w_full & ~w_pop;

    assign out_valid  = ~w_empty;
    assign out_data   = w_empty ? '0 : r_mem[r_rptr];
    assign bit_cnt    = r_bit_cnt;
    assign overflow   = r_overflow;

    // Collector FSM: IDLE holds no bits, COLLECT holds 1..WORD_W-1 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid && !flush) begin
                        r_state   <= S_COLLECT;
                        r_shift   <= w_word;
                        r_bit_cnt <= 5'd1;
                    end
                end
                S_COLLECT: begin
                    if (flush || w_complete) begin
                        r_state   <= S_IDLE;
                        r_shift   <= '0;
                        r_bit_cnt <= '0;
                    end else if (in_valid) begin
                        r_shift   <= w_word;
                        r_bit_cnt <= r_bit_cnt + 5'd1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_shift   <= '0;
                    r_bit_cnt <= '0;
                end
            endcase
        end
    end

    // Word FIFO; pointers wrap naturally since FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= w_word;
                r_wptr        <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
            // A new drop beats a simultaneous clear.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

`ifdef FSM_OUT_COLLECTOR_PARITY_EN
    logic r_par [FIFO_DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_par[i] <= 1'b0;
            end
        end else if (w_push) begin
            r_par[r_wptr] <= ^w_word;
        end
    end

    assign out_parity = w_empty ? 1'b0 : r_par[r_rptr];
`endif

endmodule

// File: doc/fsm_out_collector.md
FSM_OUT_COLLECTOR -- requirements
Module: fsm_out_collector

Interface
- REQ-001: Parameter WORD_W, default 8, word width in bits; legal range 2..32.
- REQ-002: Parameter FIFO_DEPTH, default 4, word buffer depth; power of two, 2..16.
- REQ-003: Port clk, input, 1, the single clock; all state updates on the rising edge.
- REQ-004: Port reset, input, 1, asynchronous, active-high reset.
- REQ-005: Port in_valid, input, 1, in_bit is valid this cycle.
- REQ-006: Port in_bit, input, 1, serial output bit of the upstream Mealy FSM.
- REQ-007: Port flush, input, 1, synchronous discard of the partial word.
- REQ-008: Port ovf_clr, input, 1, synchronous clear of the overflow flag.
- REQ-009: Port out_ready, input, 1, consumer accepts out_data this cycle.
- REQ-010: Port out_valid, output, 1, FIFO non-empty; out_data is valid.
- REQ-011: Port out_data, output, WORD_W, head-of-FIFO word.
- REQ-012: Port bit_cnt, output, 5, number of bits held in the partial word.
- REQ-013: Port overflow, output, 1, sticky flag: a completed word was dropped.

Function
- REQ-014: The collector FSM has two states: IDLE (bit_cnt = 0) and COLLECT (0 < bit_cnt < WORD_W).
- REQ-015: IDLE -> COLLECT on in_valid with flush low; COLLECT -> IDLE on flush, or on in_valid when bit_cnt = WORD_W-1.
- REQ-016: Bits are assembled MSB-first: the first accepted bit lands in out_data[WORD_W-1] and the last in out_data[0].
- REQ-017: bit_cnt increments by 1 per accepted bit and wraps from WORD_W-1 to 0 on word completion.
- REQ-018: On the completing edge, the word {shift[WORD_W-2:0], in_bit} is pushed into the FIFO on that same edge.
- REQ-019: Latency is one cycle: out_valid is high in the cycle after the completing edge when the FIFO was empty.
- REQ-020: A pop occurs on any edge where out_valid and out_ready are both high; out_data then advances to the next entry or out_valid falls.
- REQ-021: out_data is held stable while out_valid is high and out_ready is low.
- REQ-022: A push to a full FIFO with no simultaneous pop drops the word, leaves the FIFO unchanged and sets overflow.
- REQ-023: A push to a full FIFO with a simultaneous pop is accepted; occupancy stays full and no overflow occurs.
- REQ-024: A push and a pop on a non-full, non-empty FIFO leave occupancy unchanged.
- REQ-025: Flush takes priority over in_valid: the bit presented in that cycle is discarded, bit_cnt becomes 0 and FIFO contents are unaffected.
- REQ-026: When ovf_clr and a new overflow event occur in the same cycle, overflow remains set (set wins).
- REQ-027: FIFO read and write pointers wrap modulo FIFO_DEPTH; occupancy uses one extra bit to distinguish full from empty.

Reset
- REQ-028: Asserting reset at any time, including mid-word or with the FIFO partly full, asynchronously forces state IDLE, bit_cnt = 0, shift register = 0, FIFO empty, out_valid = 0, out_data = 0 and overflow = 0.
- REQ-029: The first accepted bit after reset deassertion is treated as bit WORD_W-1 of a new word.

Configuration
- REQ-030: When the macro FSM_OUT_COLLECTOR_PARITY_EN is defined, a 1-bit output port out_parity is added.
- REQ-031: out_parity carries the XOR of the head word, is computed at push time and stored in the FIFO with the word, and resets to 0.
- REQ-032: When FSM_OUT_COLLECTOR_PARITY_EN is undefined, out_parity and its storage are absent and all other behaviour is identical.

Verification
- REQ-033: Defaults, bits 1,0,1,1,0,0,1,0 on consecutive cycles, out_ready = 1 -> out_valid high for one cycle after the 8th edge with out_data = 8'hB2; out_parity = 0 when enabled.
- REQ-034: out_ready = 0, five complete words pushed -> four words retained in order, overflow = 1 after the 5th completion, the fifth word is lost; ovf_clr pulse -> overflow = 0.
- REQ-035: FIFO full, out_ready = 1 in the same cycle as the 8th bit of a new word -> word accepted, overflow stays 0, FIFO remains full.
- REQ-036: Three bits accepted, then flush together with in_valid -> bit_cnt = 0; the next eight bits 8'hFF yield out_data = 8'hFF.
- REQ-037: Reset asserted asynchronously mid-cycle with bit_cnt = 5 and two words buffered -> out_valid = 0, bit_cnt = 0 and overflow = 0 immediately, before the next clock edge.
